// File: rtl/lifo_stack_pkg.sv
// Shared types for the LIFO stack: request decode and occupancy width helper.
// No logic, no latency.
// No flow control.
package stack_pkg;

    // Encoding matches {push, pop} so a plain cast decodes the request pair.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } stack_op_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// Request/status bundle between the controller (master) and the stack (slave).
// No latency of its own.
// Strobe-only requests, no back-pressure.
interface lifo_stack_if #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
);
    import stack_pkg::*;

    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] in;
    logic             push;
    logic             pop;
    logic             clear;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output in, push, pop, clear,
        input  out, out_valid, top, count, empty, full, overflow, underflow
    );

    modport slave (
        input  in, push, pop, clear,
        output out, out_valid, top, count, empty, full, overflow, underflow
    );

endinterface

// File: rtl/lifo_stack_mem.sv
// WIDTH x DEPTH register array, one synchronous write port, one async read port.
// Write visible on the read port the cycle after the write edge.
// No flow control; contents are not reset.
module stack_mem #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack over a circular register array (top/bottom pointers).
// Pop data and status registered, one-cycle latency; top peek is register-only.
// No back-pressure: one push/pop/replace per clock at any rate, full policy by OVERWRITE.
module lifo_stack #(
    parameter int WIDTH     = 12,
    parameter int DEPTH     = 8,
    parameter int OVERWRITE = 0
) (
    input  logic         clk,
    input  logic         rst,
    lifo_stack_if.slave  bus
);
    import stack_pkg::*;

    localparam int              CW       = cnt_w(DEPTH);
    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);

    // wr_ptr is the next free slot; the live top sits one below it.
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    bot_ptr;
    logic [PW-1:0]    top_ptr;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] top_dat;
    logic [WIDTH-1:0] out_q;
    logic             out_vld_q;
    logic             ovf_q;
    logic             unf_q;
    logic             is_empty;
    logic             is_full;
    logic             mem_we;
    logic [PW-1:0]    mem_waddr;
    stack_op_t        op;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PTR_LAST : p - 1'b1;
    endfunction

    assign op       = stack_op_t'({bus.push, bus.pop});
    assign top_ptr  = ptr_dec(wr_ptr);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_ptr;
        if (!rst && !bus.clear) begin
            case (op)
                OP_PUSH: begin
                    if (!is_full) begin
                        mem_we = 1'b1;
                    end else if (OVERWRITE != 0) begin
                        // When full the free slot is the oldest entry's slot.
                        mem_we    = 1'b1;
                        mem_waddr = bot_ptr;
                    end
                end
                OP_SWAP: begin
                    if (!is_empty) begin
                        mem_we    = 1'b1;
                        mem_waddr = top_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (bus.in),
        .raddr (top_ptr),
        .rdata (top_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            bot_ptr   <= '0;
            count_q   <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr    <= '0;
            bot_ptr   <= '0;
            count_q   <= '0;
            out_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            out_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            case (op)
                OP_PUSH: begin
                    if (!is_full) begin
                        wr_ptr  <= ptr_inc(wr_ptr);
                        count_q <= count_q + 1'b1;
                    end else begin
                        ovf_q <= 1'b1;
                        if (OVERWRITE != 0) begin
                            wr_ptr  <= ptr_inc(wr_ptr);
                            bot_ptr <= ptr_inc(bot_ptr);
                        end
                    end
                end
                OP_POP: begin
                    if (!is_empty) begin
                        out_q     <= top_dat;
                        out_vld_q <= 1'b1;
                        wr_ptr    <= top_ptr;
                        count_q   <= count_q - 1'b1;
                    end else begin
                        unf_q <= 1'b1;
                    end
                end
                OP_SWAP: begin
                    // Empty replace-top degenerates to a pass-through.
                    out_q     <= is_empty ? bus.in : top_dat;
                    out_vld_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_vld_q;
    assign bus.top       = is_empty ? '0 : top_dat;
    assign bus.count     = count_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_FULL);
    a_full_ptrs: assert property (@(posedge clk) disable iff (rst)
        is_full |-> (wr_ptr == bot_ptr));

endmodule

// File: tb/tb_lifo_stack.sv
// Drives OVERWRITE=0 and OVERWRITE=1 stacks with identical stimulus and checks
// both against an array-based stack model every cycle, plus literal spot values.
module tb_lifo_stack;
    import stack_pkg::*;

    localparam int W  = 12;
    localparam int D  = 8;
    localparam int CW = cnt_w(D);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lifo_stack_if #(.WIDTH(W), .DEPTH(D)) b0 ();
    lifo_stack_if #(.WIDTH(W), .DEPTH(D)) b1 ();

    lifo_stack #(.WIDTH(W), .DEPTH(D), .OVERWRITE(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    lifo_stack #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    // Model: index 0 is the bottom, mstk[k][msz[k]-1] the top. k=1 is the overwrite stack.
    logic [W-1:0] mstk [2][D];
    int           msz  [2];
    logic [W-1:0] mout [2];
    bit           mvld [2];
    bit           movf [2];
    bit           munf [2];

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic model_step(input int k, input bit r, input bit c, input bit pu,
                              input bit po, input logic [W-1:0] d);
        if (r) begin
            msz[k] = 0; mout[k] = '0; mvld[k] = 0; movf[k] = 0; munf[k] = 0;
        end else if (c) begin
            msz[k] = 0; mvld[k] = 0; movf[k] = 0; munf[k] = 0;
        end else begin
            mvld[k] = 0; movf[k] = 0; munf[k] = 0;
            if (pu && po) begin
                if (msz[k] == 0) begin
                    mout[k] = d;
                end else begin
                    mout[k] = mstk[k][msz[k]-1];
                    mstk[k][msz[k]-1] = d;
                end
                mvld[k] = 1;
            end else if (pu) begin
                if (msz[k] < D) begin
                    mstk[k][msz[k]] = d;
                    msz[k]++;
                end else begin
                    movf[k] = 1;
                    if (k == 1) begin
                        for (int i = 0; i < D - 1; i++) mstk[k][i] = mstk[k][i+1];
                        mstk[k][D-1] = d;
                    end
                end
            end else if (po) begin
                if (msz[k] > 0) begin
                    msz[k]--;
                    mout[k] = mstk[k][msz[k]];
                    mvld[k] = 1;
                end else begin
                    munf[k] = 1;
                end
            end
        end
    endtask

    task automatic cmp(input string p, input int k, input logic [W-1:0] o, input logic v,
                       input logic [W-1:0] t, input logic [CW-1:0] n, input logic e,
                       input logic f, input logic ov, input logic un);
        logic [W-1:0] et;
        et = (msz[k] > 0) ? mstk[k][msz[k]-1] : '0;
        check({p, ".out"},       32'(o),  32'(mout[k]));
        check({p, ".out_valid"}, 32'(v),  32'(mvld[k]));
        check({p, ".top"},       32'(t),  32'(et));
        check({p, ".count"},     32'(n),  32'(msz[k]));
        check({p, ".empty"},     32'(e),  32'(msz[k] == 0));
        check({p, ".full"},      32'(f),  32'(msz[k] == D));
        check({p, ".overflow"},  32'(ov), 32'(movf[k]));
        check({p, ".underflow"}, 32'(un), 32'(munf[k]));
    endtask

    always @(negedge clk) begin
        if (armed) begin
            cmp("u0", 0, b0.out, b0.out_valid, b0.top, b0.count, b0.empty, b0.full, b0.overflow, b0.underflow);
            cmp("u1", 1, b1.out, b1.out_valid, b1.top, b1.count, b1.empty, b1.full, b1.overflow, b1.underflow);
        end
    end

    task automatic cyc(input bit r, input bit c, input bit pu, input bit po, input logic [W-1:0] d);
        rst = r;
        b0.clear = c; b0.push = pu; b0.pop = po; b0.in = d;
        b1.clear = c; b1.push = pu; b1.pop = po; b1.in = d;
        @(posedge clk);
        model_step(0, r, c, pu, po, d);
        model_step(1, r, c, pu, po, d);
        if (r) armed = 1'b1;
        @(negedge clk);
    endtask

    logic [W-1:0] ow_exp [8] = '{12'hBBB, 12'hAAA, 12'h008, 12'h007, 12'h006, 12'h005, 12'h004, 12'h003};

    initial begin
        b0.clear = 0; b0.push = 0; b0.pop = 0; b0.in = '0;
        b1.clear = 0; b1.push = 0; b1.pop = 0; b1.in = '0;

        cyc(1, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, '0);
        check("rst_count", 32'(b0.count), 32'd0);
        check("rst_empty", 32'(b0.empty), 32'd1);
        check("rst_out",   32'(b0.out),   32'd0);

        for (int i = 1; i <= 8; i++) cyc(0, 0, 1, 0, W'(i));
        check("fill_count", 32'(b0.count), 32'd8);
        check("fill_full",  32'(b0.full),  32'd1);
        check("fill_top",   32'(b0.top),   32'h008);

        cyc(0, 0, 1, 0, 12'hAAA);
        check("rej_ovf",   32'(b0.overflow), 32'd1);
        check("rej_count", 32'(b0.count),    32'd8);
        check("rej_top",   32'(b0.top),      32'h008);
        check("ow_top",    32'(b1.top),      32'hAAA);
        cyc(0, 0, 1, 0, 12'hBBB);
        check("ow_ovf2",   32'(b1.overflow), 32'd1);
        check("ow_top2",   32'(b1.top),      32'hBBB);

        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, '0);
            check("pop_seq_rej", 32'(b0.out), 32'(8 - i));
            check("pop_seq_ow",  32'(b1.out), 32'(ow_exp[i]));
            check("pop_vld",     32'(b0.out_valid), 32'd1);
        end
        check("drain_empty", 32'(b0.empty), 32'd1);

        cyc(0, 0, 0, 1, '0);
        check("unf_pulse", 32'(b0.underflow), 32'd1);
        check("unf_vld",   32'(b0.out_valid), 32'd0);
        check("unf_out",   32'(b0.out),       32'h001);

        cyc(0, 0, 1, 1, 12'h5A5);
        check("pass_out",   32'(b0.out),       32'h5A5);
        check("pass_vld",   32'(b0.out_valid), 32'd1);
        check("pass_count", 32'(b0.count),     32'd0);

        cyc(0, 0, 1, 0, 12'h111);
        cyc(0, 0, 1, 0, 12'h222);
        cyc(0, 0, 1, 1, 12'h333);
        check("swap_out",   32'(b0.out),   32'h222);
        check("swap_count", 32'(b0.count), 32'd2);
        check("swap_top",   32'(b0.top),   32'h333);

        for (int i = 1; i <= 6; i++) cyc(0, 0, 1, 0, W'(12'h600 + i));
        cyc(0, 0, 1, 1, 12'h444);
        check("fswap_ovf",   32'(b0.overflow), 32'd0);
        check("fswap_out",   32'(b0.out),      32'h606);
        check("fswap_count", 32'(b0.count),    32'd8);
        check("fswap_top",   32'(b1.top),      32'h444);

        cyc(0, 1, 0, 0, '0);
        for (int i = 1; i <= 3; i++) cyc(0, 0, 1, 0, W'(12'h700 + i));
        cyc(0, 1, 1, 0, 12'h7FF);
        check("clr_count", 32'(b0.count), 32'd0);
        check("clr_empty", 32'(b0.empty), 32'd1);
        check("clr_out",   32'(b0.out),   32'h606);
        cyc(0, 0, 1, 0, 12'h123);
        check("clr_next_top", 32'(b0.top), 32'h123);

        cyc(0, 0, 1, 0, 12'h801);
        cyc(1, 0, 1, 0, 12'h802);
        check("mrst_out",   32'(b0.out),   32'd0);
        check("mrst_count", 32'(b0.count), 32'd0);
        cyc(0, 0, 1, 0, 12'h901);
        check("mrst_next_top", 32'(b1.top), 32'h901);

        for (int i = 0; i < 4000; i++) begin
            int pp;
            bit pu, po, c, r;
            pp = ((i / 200) % 2 == 1) ? 75 : 25;
            pu = ($urandom_range(0, 99) < 50);
            po = ($urandom_range(0, 99) < (100 - pp));
            if (!pu) pu = ($urandom_range(0, 99) < pp) && !po;
            c  = ($urandom_range(0, 63) == 0);
            r  = ($urandom_range(0, 127) == 0);
            cyc(r, c, pu, po, W'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
